chunked_seq_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock. The carry is held in a register between chunks. It replaces the single-bit full-adder datapath feeding the FND display path for operand widths where a full-width ripple chain is too slow. A start/valid handshake lets the display controller launch an operation and collect a held result.

---
 rtl/adder_pkg.sv | 20 ++
 rtl/chunk_adder.sv | 32 +++
 rtl/full_adder.sv | 13 +
 rtl/chunked_seq_adder.sv | 150 +++++++++++++++
 tb/tb_chunked_seq_adder.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Chunk index width: clog2 of the chunk count, never below one bit.
    function automatic int cnt_width(input int width, input int chunk);
        int nch;
        nch = width / chunk;
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from FullAdder cells.
// c_msb_in exposes the carry into the chunk MSB so the caller can form
// two's-complement overflow when this chunk holds the operand MSB.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        FullAdder u_fa (
            .A    (a[i]),
            .B    (b[i]),
            .Cin  (w_c[i]),
            .Sum  (sum[i]),
            .Cout (w_c[i+1])
        );
    end

    assign cout     = w_c[CHUNK];
    assign c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder, the leaf cell of the chunk ripple chain.
module FullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: adds a WIDTH-bit pair CHUNK bits per clock,
// holding the inter-chunk carry in a register. Results are published only on
// the completing edge and held until the next completion or reset.
// Optional feature macro: ADDER_SUB_EN (honour i_sub for A - B).
module chunked_seq_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Cin,
    input  logic             i_sub,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_Sum,
    output logic             o_Cout,
    output logic             o_Ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = cnt_width(WIDTH, CHUNK);
    localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

    if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
        $error("chunked_seq_adder: CHUNK must lie in 1..WIDTH");
    end
    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("chunked_seq_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_idx;

    logic [WIDTH-1:0] w_b_in;
    logic             w_c0;
    logic [CHUNK-1:0] w_a_ch;
    logic [CHUNK-1:0] w_b_ch;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;

`ifdef ADDER_SUB_EN
    // Subtract as A + ~B + 1; the caller's carry-in is dropped in that mode.
    assign w_b_in = i_sub ? ~i_B : i_B;
    assign w_c0   = i_sub ? 1'b1 : i_Cin;
`else
    // Add-only build: i_sub is accepted on the port but has no effect.
    logic w_unused_sub;
    assign w_unused_sub = i_sub;
    assign w_b_in       = i_B;
    assign w_c0         = i_Cin;
`endif

    // Pick the operand slices addressed by the current chunk index.
    always_comb begin
        w_a_ch = '0;
        w_b_ch = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_idx == CW'(k)) begin
                w_a_ch = r_a[k*CHUNK +: CHUNK];
                w_b_ch = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a        (w_a_ch),
        .b        (w_b_ch),
        .cin      (r_carry),
        .sum      (w_sum),
        .cout     (w_cout),
        .c_msb_in (w_cmsb)
    );

    // Merge this cycle's chunk sum into the working result.
    always_comb begin
        w_res_next = r_res;
        for (int k = 0; k < NCH; k++) begin
            if (r_idx == CW'(k)) begin
                w_res_next[k*CHUNK +: CHUNK] = w_sum;
            end
        end
    end

    assign w_last = (r_idx == LAST_IDX);

    // Control FSM plus operand, carry, working and published result registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_Sum   <= '0;
            o_Cout  <= 1'b0;
            o_Ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_a     <= i_A;
                        r_b     <= w_b_in;
                        r_carry <= w_c0;
                        r_idx   <= '0;
                        r_state <= ST_BUSY;
                        o_busy  <= 1'b1;
                        o_valid <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    if (w_last) begin
                        // Index parks at the last chunk; it is cleared on accept.
                        r_state <= ST_DONE;
                        o_busy  <= 1'b0;
                        o_valid <= 1'b1;
                        o_Sum   <= w_res_next;
                        o_Cout  <= w_cout;
                        o_Ovf   <= w_cmsb ^ w_cout;
                    end else begin
                        r_idx <= r_idx + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Scoreboard bench for chunked_seq_adder (WIDTH=16, CHUNK=4). Stimulus pushes
// hand-computed results; a negedge monitor pops on each o_valid rise.
module tb_chunked_seq_adder;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic [15:0] i_A;
    logic [15:0] i_B;
    logic        i_Cin;
    logic        i_sub;
    logic        o_busy;
    logic        o_valid;
    logic [15:0] o_Sum;
    logic        o_Cout;
    logic        o_Ovf;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t        q[$];
    int          n_pass;
    int          n_total;
    logic [15:0] last_sum;
    logic        prev_v;

    logic [15:0] cont_a[3] = '{16'h1000, 16'h2000, 16'h3000};
    logic [15:0] cont_b[3] = '{16'h0011, 16'h0022, 16'h0033};
    logic [15:0] cont_s[3] = '{16'h1011, 16'h2022, 16'h3033};

    chunked_seq_adder #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_A     (i_A),
        .i_B     (i_B),
        .i_Cin   (i_Cin),
        .i_sub   (i_sub),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .o_Sum   (o_Sum),
        .o_Cout  (o_Cout),
        .o_Ovf   (o_Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    // Monitor: every rising o_valid consumes one scoreboard entry.
    always @(negedge clk) begin : mon
        exp_t e;
        if (i_reset) begin
            prev_v <= 1'b0;
        end else begin
            if (o_valid && !prev_v) begin
                if (q.size() == 0) begin
                    chk("spurious_result", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    chk("sum",  32'(o_Sum),  32'(e.sum));
                    chk("cout", 32'(o_Cout), 32'(e.cout));
                    chk("ovf",  32'(o_Ovf),  32'(e.ovf));
                end
            end
            prev_v <= o_valid;
        end
    end

    // mode 0: plain op, 1: stray start in busy cycle 2, 2: reset in busy cycle 2
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic [15:0] es, input logic ec,
                          input logic eo, input int mode);
        int cyc;
        int bsy;
        if (mode != 2) q.push_back('{sum: es, cout: ec, ovf: eo});
        i_A = a; i_B = b; i_Cin = cin; i_sub = sub; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_A = '0; i_B = '0; i_Cin = 1'b0; i_sub = 1'b0;
        chk("valid_drop", 32'(o_valid), 32'd0);
        cyc = 0;
        bsy = int'(o_busy);
        while (!o_valid && cyc < 20) begin
            if (cyc == 1 && mode == 1) begin
                i_start = 1'b1; i_A = 16'hAAAA; i_B = 16'h5555;
            end
            if (cyc == 2) begin
                i_start = 1'b0; i_A = '0; i_B = '0;
                chk("hold_in_busy", 32'(o_Sum), 32'(last_sum));
                if (mode == 2) begin
                    i_reset = 1'b1;
                    #1;
                    chk("rst_busy",  32'(o_busy),  32'd0);
                    chk("rst_valid", 32'(o_valid), 32'd0);
                    chk("rst_sum",   32'(o_Sum),   32'd0);
                    chk("rst_cout",  32'(o_Cout),  32'd0);
                    chk("rst_ovf",   32'(o_Ovf),   32'd0);
                    @(negedge clk);
                    i_reset = 1'b0;
                    last_sum = '0;
                    @(posedge clk); #1;
                    return;
                end
            end
            @(posedge clk); #1;
            cyc++;
            bsy += int'(o_busy);
        end
        chk("latency",     32'(cyc), 32'd4);
        chk("busy_cycles", 32'(bsy), 32'd4);
        last_sum = es;
    endtask

    initial begin : stim
        n_pass = 0; n_total = 0; last_sum = '0;
        i_reset = 1'b1; i_start = 1'b0; i_A = '0; i_B = '0; i_Cin = 1'b0; i_sub = 1'b0;
        #2;
        chk("reset_busy",  32'(o_busy),  32'd0);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_sum",   32'(o_Sum),   32'd0);
        chk("reset_cout",  32'(o_Cout),  32'd0);
        chk("reset_ovf",   32'(o_Ovf),   32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        @(posedge clk); #1;

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        run_op(16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 1);
        @(posedge clk); #1;
        chk("stray_start_busy",  32'(o_busy),  32'd0);
        chk("stray_start_valid", 32'(o_valid), 32'd1);
        chk("stray_start_sum",   32'(o_Sum),   32'h2346);

`ifdef ADDER_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
`else
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 0);
`endif

        run_op(16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0);

        // Start held high: one accept every 5 edges, one-cycle valid pulses.
        for (int r = 0; r < 3; r++) begin
            q.push_back('{sum: cont_s[r], cout: 1'b0, ovf: 1'b0});
            i_A = cont_a[r]; i_B = cont_b[r]; i_Cin = 1'b0; i_start = 1'b1;
            @(posedge clk); #1;
            chk("cont_busy",  32'(o_busy),  32'd1);
            chk("cont_valid_low", 32'(o_valid), 32'd0);
            i_A = 16'hDEAD; i_B = 16'hBEEF;
            for (int e = 0; e < 3; e++) begin
                @(posedge clk); #1;
                chk("cont_valid_low", 32'(o_valid), 32'd0);
            end
            chk("cont_hold", 32'(o_Sum), 32'(last_sum));
            @(posedge clk); #1;
            chk("cont_valid_high", 32'(o_valid), 32'd1);
            last_sum = cont_s[r];
        end
        i_start = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
